// File: rtl/nibble_alu_pkg.sv
// Shared types and constants for the nibble ALU command sequencer.
package nibble_alu_pkg;

    localparam int HOLD_DEFAULT = 6;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_OUT
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

endpackage

// File: rtl/nibble_cmd_fifo.sv
// DEPTH x 10-bit command FIFO; guarded push/pop, pointers wrap mod DEPTH.
module nibble_cmd_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [9:0]    din,
    input  logic          pop,
    output logic [9:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [9:0]    mem_q [DEPTH];
    logic [9:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/nibble_alu_seq.sv
// Sequences queued commands through an external nibble ALU, holding its
// inputs HOLD cycles before capturing the result into a stable output.
module nibble_alu_seq
    import nibble_alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HOLD  = HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [1:0] cmd_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [3:0] alu_s,
    input  logic       alu_cout,
    input  logic       alu_valid,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_s,
    output logic       res_cout,
    output logic       busy,
    output logic       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(HOLD);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  alu_a_q, alu_a_d;
    logic [3:0]  alu_b_q, alu_b_d;
    logic [1:0]  alu_op_q, alu_op_d;
    logic [3:0]  res_s_q, res_s_d;
    logic        res_cout_q, res_cout_d;
    logic        err_q, err_d;

    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;
    cmd_t        head;

    assign cmd_ready = (fifo_count < DEPTH_C);
    assign push      = cmd_valid && cmd_ready;

    nibble_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({cmd_op, cmd_a, cmd_b}),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        res_s_d    = res_s_q;
        res_cout_d = res_cout_q;
        err_d      = err_q;
        pop        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    alu_a_d  = head.a;
                    alu_b_d  = head.b;
                    alu_op_d = head.op;
                    cnt_d    = CW'(HOLD - 1);
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    res_s_d    = alu_s;
                    res_cout_d = alu_cout;
                    err_d      = err_q | ~alu_valid;
                    state_d    = S_OUT;
                end
            end
            // No issue from OUT: the pop waits for the following IDLE cycle.
            S_OUT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            res_s_q    <= '0;
            res_cout_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            res_s_q    <= res_s_d;
            res_cout_q <= res_cout_d;
            err_q      <= err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_valid = (state_q == S_OUT);
    assign res_s     = res_s_q;
    assign res_cout  = res_cout_q;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;

    a_ready_full: assert property (
        @(posedge clk) disable iff (!rst_n) cmd_ready == !fifo_full
    );

endmodule

// File: doc/nibble_alu_seq.md
NIBBLE_ALU_SEQ -- requirements
Module: nibble_alu_seq

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO entries, power of two, at least 2.
REQ-002 Parameter HOLD, default 6: cycles the ALU inputs are held stable before the result is sampled, at least 2.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-008 cmd_a, cmd_b  in  4 each  operands.
REQ-009 cmd_op  in  2  opcode: 00 add, 01 sub, 10 and, 11 or.
REQ-010 alu_a, alu_b  out  4 each  operands driven to the downstream nibble ALU.
REQ-011 alu_op  out  2  opcode driven to the ALU.
REQ-012 alu_s  in  4  ALU result.
REQ-013 alu_cout  in  1  ALU carry (borrow on sub).
REQ-014 alu_valid  in  1  ALU valid flag.
REQ-015 res_valid  out  1  result available.
REQ-016 res_ready  in  1  consumer accepts the result.
REQ-017 res_s  out  4  result.
REQ-018 res_cout  out  1  result carry.
REQ-019 busy  out  1  state is not IDLE.
REQ-020 err  out  1  sticky flag: alu_valid was low at a capture edge.

Function
REQ-021 Commands SHALL enter a DEPTH-entry FIFO of {op,a,b}.
- Read and write pointers wrap modulo DEPTH.
- Commands issue in arrival order.
REQ-022 cmd_ready SHALL equal (count < DEPTH).
- When full, a pop in the same cycle does not raise cmd_ready (no bypass).
REQ-023 The FSM SHALL have three states: IDLE, ISSUE and OUT.
REQ-024 IDLE, count > 0:
- Pop the head into alu_a, alu_b and alu_op.
- Load the hold counter with HOLD-1 and go to ISSUE.
REQ-025 IDLE, count = 0: remain in IDLE.
REQ-026 ISSUE, counter > 0: decrement the counter; alu_a, alu_b and alu_op stay unchanged.
REQ-027 ISSUE, counter = 0, at that edge:
- Register alu_s into res_s and alu_cout into res_cout.
- Set err if alu_valid = 0.
- Go to OUT.
REQ-028 OUT: res_valid = 1.
- When res_ready = 1, go to IDLE and drop res_valid on the next cycle.
- No new issue occurs in the same cycle.
REQ-029 While res_valid = 1 and res_ready = 0, res_s and res_cout SHALL stay stable.
REQ-030 Latency from the command-accept edge to res_valid, with an empty FIFO and idle FSM, SHALL be HOLD+1 cycles.
- Throughput is at most one command per HOLD+2 cycles.
REQ-031 Between commands, alu_a, alu_b and alu_op SHALL hold the last issued values.
REQ-032 err SHALL be cleared only by reset; the result is still delivered when err is set.
REQ-033 A simultaneous push and pop SHALL leave count unchanged.
REQ-034 An empty FIFO SHALL never be popped, and a full FIFO SHALL never be written.

Reset
REQ-035 rst_n low SHALL immediately:
- Set state IDLE, pointers and count to 0.
- Clear res_valid, res_s, res_cout, alu_a, alu_b, alu_op, busy and err.
- Hold cmd_ready at 1.
REQ-036 Reset during ISSUE or OUT SHALL discard the in-flight command and all queued commands; no result is emitted.
REQ-037 The first command SHALL be acceptable on the first rising edge after rst_n deasserts.

Structure
REQ-038 Shared package nibble_alu_pkg SHALL hold:
- Opcode constants OP_ADD, OP_SUB, OP_AND, OP_OR.
- The FSM state type.
- The default HOLD value.
REQ-039 The FIFO SHALL be the sub-module nibble_cmd_fifo (DEPTH x 10 bits, push/pop/full/empty/count); the FSM and result register stay in nibble_alu_seq.

Verification
REQ-040 Single add: ADD a=3, b=4, res_ready=1 -> res_valid rises HOLD+1 cycles after accept with res_s=7, res_cout=0, asserted for exactly 1 cycle.
REQ-041 In-order mix: ADD, SUB, AND, OR with a=C, b=A each -> results in order:
- res_s=6 with res_cout=1.
- res_s=2 with res_cout=0.
- res_s=8 with res_cout=1.
- res_s=E with res_cout=1.
REQ-042 Full: res_ready=0, push 6 commands back-to-back -> 5 accepted (1 in OUT plus DEPTH queued), cmd_ready low on the 6th; a single res_ready pulse leaves cmd_ready low until the next IDLE pop.
REQ-043 Backpressure: res_ready=0 for 20 cycles -> res_s and res_cout constant throughout; after res_ready=1 for one cycle, res_valid falls on the next cycle and the next result follows HOLD+2 cycles later.
REQ-044 Error: ALU model drives alu_valid=0 for one command -> err=1 from the capture edge onward, the result is still delivered, err stays 1 for later good commands.
REQ-045 Reset in ISSUE with 2 commands queued -> all outputs at reset values, no res_valid after release, cmd_ready=1.
